// File: rtl/menc_pkg.sv
// Shared types and constants for the magnetic encoder SPI reader.
package menc_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ANGLE_BITS = 14;
  localparam int unsigned EF_BIT     = 14;
  localparam int unsigned PAR_BIT    = 15;

  localparam logic [FRAME_BITS-1:0] CMD_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_CHECK,
    ST_GAP
  } menc_state_e;

  // A frame is rejected on odd overall parity or when the encoder raises its error flag.
  function automatic logic frame_bad(input logic [FRAME_BITS-1:0] w);
    return ((^w[PAR_BIT-1:0]) ^ w[PAR_BIT]) | w[EF_BIT];
  endfunction

endpackage

// File: rtl/menc_spi_reader_sclk_gen.sv
// SCLK half-period generator: high half first, then low half, for each bit.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_c,
  output logic fall_c,
  output logic last_c,
  output logic sclk
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    sclk_d  = 1'b0;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else begin
      sclk_d = !phase_q;
      if (cnt_q == CW'(CLK_DIV - 1)) begin
        cnt_d   = '0;
        phase_d = !phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

  assign rise_c = en && !phase_q && (cnt_q == '0);
  assign fall_c = en &&  phase_q && (cnt_q == '0);
  assign last_c = en &&  phase_q && (cnt_q == CW'(CLK_DIV - 1));
  assign sclk   = sclk_q;

endmodule

// File: rtl/menc_spi_reader.sv
// Polls the absolute encoder over SPI mode 1 and publishes the last good 14-bit angle.
module menc_spi_reader
  import menc_pkg::*;
#(
  parameter int unsigned           CLK_DIV  = 4,
  parameter int unsigned           POLL_GAP = 20,
  parameter logic [FRAME_BITS-1:0] CMD      = CMD_DEFAULT
) (
  input  logic                  c,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  mosi,
  output logic [FRAME_BITS-1:0] menc_raw,
  output logic                  menc_valid,
  output logic                  err,
  output logic [15:0]           err_count,
  output logic                  busy
);

  localparam int unsigned CNT_MAX = (CLK_DIV > POLL_GAP) ? CLK_DIV : POLL_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS);

  menc_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic                  primed_q, primed_d;
  logic                  fall_q;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic [FRAME_BITS-1:0] menc_raw_q, menc_raw_d;
  logic                  menc_valid_q, menc_valid_d;
  logic                  err_q, err_d;
  logic [15:0]           err_count_q, err_count_d;
  logic                  busy_q, busy_d;

  logic shift_en_c, rise_c, fall_c, last_c;

  assign shift_en_c = (state_q == ST_SHIFT);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (c),
    .rst    (rst),
    .en     (shift_en_c),
    .rise_c (rise_c),
    .fall_c (fall_c),
    .last_c (last_c),
    .sclk   (sclk)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    primed_d     = primed_q;
    mosi_d       = mosi_q;
    menc_raw_d   = menc_raw_q;
    menc_valid_d = 1'b0;
    err_d        = 1'b0;
    err_count_d  = err_count_q;
    // miso is captured one cycle after the internal fall strobe, matching the registered sclk edge
    rx_d = fall_q ? {rx_q[FRAME_BITS-2:0], miso} : rx_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          sh_d     = CMD;
          primed_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (rise_c) begin
          mosi_d = sh_q[FRAME_BITS-1];
          sh_d   = {sh_q[FRAME_BITS-2:0], 1'b0};
        end
        if (last_c) begin
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        // The encoder answers the previous command, so the first frame of a run carries stale data
        if (primed_q) begin
          if (frame_bad(rx_q)) begin
            err_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          end else begin
            menc_raw_d   = {{(FRAME_BITS - ANGLE_BITS){1'b0}}, rx_q[ANGLE_BITS-1:0]};
            menc_valid_d = 1'b1;
          end
        end
        primed_d = 1'b1;
        cnt_d    = '0;
        state_d  = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(POLL_GAP - 1)) begin
          cnt_d = '0;
          if (en) begin
            sh_d    = CMD;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cs_n_d = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
    busy_d = (state_q != ST_IDLE);
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      rx_q         <= '0;
      primed_q     <= 1'b0;
      fall_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      menc_raw_q   <= '0;
      menc_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      rx_q         <= rx_d;
      primed_q     <= primed_d;
      fall_q       <= fall_c;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
      menc_raw_q   <= menc_raw_d;
      menc_valid_q <= menc_valid_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
      busy_q       <= busy_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign mosi       = mosi_q;
  assign menc_raw   = menc_raw_q;
  assign menc_valid = menc_valid_q;
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign busy       = busy_q;

endmodule
